iir_biquad_mc: RTL
==================

# iir_biquad_mc

Time-multiplexed, multi-channel cascaded biquad IIR filter for the offline spike-processing FPGA path. On each ADC strobe it processes one sample per channel through NUM_STAGES second-order sections, using a single shared multiplier-accumulator. Coefficients are runtime-writable. It generalises the single-channel IIR filter: same CLK/EN/START_FLAG/DATA_VALID handshake, plus channel count, cascade depth, I/O format mode, and overrun/saturation flags.

## Interface
- BITWIDTH, 16: sample and coefficient width.
- NUM_CH, 4: channels, processed in order ch0..ch(NUM_CH-1).
- NUM_STAGES, 2: cascaded biquad sections per channel.
- FRAC, 14: coefficient fractional bits. The default format is signed Q2.14.
- SIGNED_IO, 0: I/O format. 0 = offset-binary (midscale = zero); 1 = two's complement.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  enable. Low aborts the current frame and clears all histories.
- START_FLAG  in  1  ADC strobe; the rising edge starts a frame.
- DATA_IN  in  NUM_CH*BITWIDTH  channel c occupies bits [c*BITWIDTH +: BITWIDTH].
- COEFF_WE  in  1  coefficient write strobe.
- COEFF_ADDR  in  ceil(log2(5*NUM_STAGES))  address = stage*5 + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- COEFF_DATA  in  BITWIDTH  signed coefficient.
- DATA_OUT  out  NUM_CH*BITWIDTH  filtered samples, same packing and format as DATA_IN.
- DATA_VALID  out  1  one-cycle pulse when DATA_OUT updates.
- BUSY  out  1  high while a frame is in progress.
- OVERRUN  out  1  sticky flag: a start edge arrived while BUSY.
- SATURATED  out  1  sticky flag: some section output clipped.

## Operation
- Section equation (Direct Form I): y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- Each section of each channel keeps its own x1, x2, y1, y2 registers (signed BITWIDTH).
- Coefficients are shared across channels.
- Stage s output is the x input of stage s+1. The last stage output goes to DATA_OUT.
- Input conversion: SIGNED_IO=0 inverts the MSB on input and on output.
- FSM states:
  - IDLE: a START_FLAG rising edge with EN=1 moves to LOAD.
  - LOAD (1 cycle): latch all of DATA_IN; ch=0, st=0.
  - MAC (5 cycles): k=0..4, one product per cycle into the accumulator, which is cleared at k=0.
  - UPD (1 cycle): round, saturate, shift the history registers, then advance st, then ch. Go to MAC if work remains, else to DONE.
  - DONE (1 cycle): register DATA_OUT, pulse DATA_VALID, return to IDLE.
- Arithmetic widths: product 2·BITWIDTH bits; accumulator 2·BITWIDTH+3 bits, signed.
- Result = (acc + 2^(FRAC−1)) >>> FRAC, saturated to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1]. Clipping sets SATURATED.
- Coefficient writes are accepted only when BUSY=0; writes while BUSY are dropped.
- Coefficient reset value: b0 = 2^FRAC (1.0), all other coefficients 0, giving passthrough.
- EN low: next edge goes to IDLE, all histories are zeroed, OVERRUN and SATURATED are cleared, DATA_OUT holds its value.
- A start edge while BUSY is ignored and sets OVERRUN.

## Timing
- Reset values:
  - DATA_OUT per channel = 2^(BITWIDTH−1) if SIGNED_IO=0, else 0.
  - DATA_VALID, BUSY, OVERRUN, SATURATED = 0.
  - Histories zeroed; coefficients at their reset values; FSM in IDLE.
- START_FLAG is edge-detected via one register. A level held high does not retrigger.
- Latency: DATA_VALID is high in the cycle 1 + 6·NUM_CH·NUM_STAGES after the edge that detects the START rising edge. This is 49 cycles at defaults.
- BUSY is high from LOAD through DONE inclusive.
- A START edge coinciding with the DONE cycle counts as overrun.
- RST mid-frame: all state returns to reset values immediately, with no DATA_VALID pulse.
- Minimum START period: 2 + 6·NUM_CH·NUM_STAGES cycles.

## Test plan
- Reset, passthrough (defaults): ch0=0x9000, ch1=0x7000 → after 49 cycles DATA_OUT ch0=0x9000, ch1=0x7000; exactly one DATA_VALID pulse; BUSY low afterwards.
- Gain: write addr0 (stage 0 b0) = 0x2000 (0.5); input 0xC000 → output 0xA000. Write attempted while BUSY → coefficient unchanged.
- Recursion and channel independence (SIGNED_IO=1): stage 0 a1=0xE000 (−0.5). Impulse 8192 on ch1 only, then zeros → ch1 outputs 8192, 4096, 2048, 1024; other channels stay 0.
- Saturation: stage 0 b0=0x6000 (1.5), input 0x7FFF (signed mode) → output 0x7FFF, SATURATED=1 and held until EN low.
- Overrun: second START rising edge 10 cycles into a frame → ignored, OVERRUN=1, current frame completes at cycle 49 with correct data.
- Async RST asserted at cycle 20 of a frame → outputs and coefficients at reset values without waiting for a clock edge; no DATA_VALID; next frame is passthrough.

Source files
------------

// File: rtl/iir_biquad_mc.sv
// Multi-channel cascaded Direct Form I biquad IIR. One multiplier-accumulator is
// time-shared across all channels and sections. Coefficients are shared by all channels.
module iir_biquad_mc #(
  parameter int BITWIDTH   = 16,
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 2,
  parameter int FRAC       = 14,
  parameter int SIGNED_IO  = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            EN,
  input  logic                            START_FLAG,
  input  logic [NUM_CH*BITWIDTH-1:0]      DATA_IN,
  input  logic                            COEFF_WE,
  input  logic [$clog2(5*NUM_STAGES)-1:0] COEFF_ADDR,
  input  logic [BITWIDTH-1:0]             COEFF_DATA,
  output logic [NUM_CH*BITWIDTH-1:0]      DATA_OUT,
  output logic                            DATA_VALID,
  output logic                            BUSY,
  output logic                            OVERRUN,
  output logic                            SATURATED
);

  localparam int NCOEF  = 5 * NUM_STAGES;
  localparam int AW     = $clog2(NCOEF);
  localparam int NSEC   = NUM_CH * NUM_STAGES;
  localparam int PROD_W = 2 * BITWIDTH;
  localparam int ACC_W  = 2 * BITWIDTH + 3;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ST_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic signed [ACC_W:0] HALF = $signed((ACC_W+1)'(1) << (FRAC - 1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_UPD, S_DONE} state_t;

  // Offset-binary <-> two's complement is an MSB flip, and it is its own inverse.
  function automatic logic [BITWIDTH-1:0] io_conv(input logic [BITWIDTH-1:0] v);
    return (SIGNED_IO == 0) ? {~v[BITWIDTH-1], v[BITWIDTH-2:0]} : v;
  endfunction

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = $signed({a[ACC_W-1], a}) + HALF;
    return t >>> FRAC;
  endfunction

  function automatic logic clips(input logic signed [ACC_W:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [BITWIDTH-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > MAXV) return MAXV[BITWIDTH-1:0];
    if (v < MINV) return MINV[BITWIDTH-1:0];
    return v[BITWIDTH-1:0];
  endfunction

  function automatic logic signed [BITWIDTH-1:0] coef_reset(input int idx);
    return (idx % 5 == 0) ? BITWIDTH'(1 << FRAC) : '0;
  endfunction

  state_t                     state_q, state_d;
  logic                       start_q;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic                       ovr_q, ovr_d;
  logic                       sat_q, sat_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [ST_W-1:0]            st_q, st_d;
  logic [2:0]                 k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [BITWIDTH-1:0] xin_q [NUM_CH];
  logic signed [BITWIDTH-1:0] xin_d [NUM_CH];
  logic signed [BITWIDTH-1:0] hx1_q [NSEC];
  logic signed [BITWIDTH-1:0] hx1_d [NSEC];
  logic signed [BITWIDTH-1:0] hx2_q [NSEC];
  logic signed [BITWIDTH-1:0] hx2_d [NSEC];
  logic signed [BITWIDTH-1:0] hy1_q [NSEC];
  logic signed [BITWIDTH-1:0] hy1_d [NSEC];
  logic signed [BITWIDTH-1:0] hy2_q [NSEC];
  logic signed [BITWIDTH-1:0] hy2_d [NSEC];
  logic signed [BITWIDTH-1:0] coef_q [NCOEF];
  logic signed [BITWIDTH-1:0] coef_d [NCOEF];
  logic [BITWIDTH-1:0]        stg_q [NUM_CH];
  logic [BITWIDTH-1:0]        stg_d [NUM_CH];
  logic [NUM_CH*BITWIDTH-1:0] dout_q, dout_d;

  int                         sec_i;
  logic signed [BITWIDTH-1:0] x_cur, x1_cur, x2_cur, y1_cur, y2_cur, coef_cur, opnd;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W:0]      rnd;
  logic signed [BITWIDTH-1:0] res;
  logic                       clip;
  logic                       start_rise;

  assign start_rise = START_FLAG & ~start_q;

  // Operand selection for the shared MAC; a later stage takes its x from the
  // freshly updated y1 of the previous stage of the same channel.
  always_comb begin
    sec_i    = int'(ch_q) * NUM_STAGES + int'(st_q);
    x_cur    = '0;
    x1_cur   = '0;
    x2_cur   = '0;
    y1_cur   = '0;
    y2_cur   = '0;
    coef_cur = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (st_q == '0 && c == int'(ch_q)) x_cur = xin_q[c];
    for (int i = 0; i < NSEC; i++) begin
      if (i == sec_i) begin
        x1_cur = hx1_q[i];
        x2_cur = hx2_q[i];
        y1_cur = hy1_q[i];
        y2_cur = hy2_q[i];
      end
      if (st_q != '0 && i == sec_i - 1) x_cur = hy1_q[i];
    end
    for (int i = 0; i < NCOEF; i++)
      if (i == int'(st_q) * 5 + int'(k_q)) coef_cur = coef_q[i];
    case (k_q)
      3'd0:    opnd = x_cur;
      3'd1:    opnd = x1_cur;
      3'd2:    opnd = x2_cur;
      3'd3:    opnd = y1_cur;
      default: opnd = y2_cur;
    endcase
    prod = PROD_W'(coef_cur) * PROD_W'(opnd);
    rnd  = round_shift(acc_q);
    res  = saturate(rnd);
    clip = clips(rnd);
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    sat_d   = sat_q;
    ch_d    = ch_q;
    st_d    = st_q;
    k_d     = k_q;
    acc_d   = acc_q;
    xin_d   = xin_q;
    hx1_d   = hx1_q;
    hx2_d   = hx2_q;
    hy1_d   = hy1_q;
    hy2_d   = hy2_q;
    coef_d  = coef_q;
    stg_d   = stg_q;
    dout_d  = dout_q;

    if (COEFF_WE && !busy_q)
      for (int i = 0; i < NCOEF; i++)
        if (COEFF_ADDR == AW'(i)) coef_d[i] = COEFF_DATA;

    if (start_rise && busy_q) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_rise && EN) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          ch_d    = '0;
          st_d    = '0;
        end
      end
      S_LOAD: begin
        for (int c = 0; c < NUM_CH; c++)
          xin_d[c] = io_conv(DATA_IN[c*BITWIDTH +: BITWIDTH]);
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        // Feedback terms k=3,4 are subtracted so stored a1/a2 keep their textbook sign.
        if (k_q == 3'd0)      acc_d = ACC_W'(prod);
        else if (k_q >= 3'd3) acc_d = acc_q - ACC_W'(prod);
        else                  acc_d = acc_q + ACC_W'(prod);
        if (k_q == 3'd4) state_d = S_UPD;
        else             k_d = k_q + 3'd1;
      end
      S_UPD: begin
        for (int i = 0; i < NSEC; i++)
          if (i == sec_i) begin
            hx2_d[i] = x1_cur;
            hx1_d[i] = x_cur;
            hy2_d[i] = y1_cur;
            hy1_d[i] = res;
          end
        if (clip) sat_d = 1'b1;
        k_d = '0;
        if (int'(st_q) == NUM_STAGES - 1) begin
          st_d = '0;
          for (int c = 0; c < NUM_CH; c++)
            if (c == int'(ch_q)) stg_d[c] = io_conv(res);
          if (int'(ch_q) == NUM_CH - 1) begin
            for (int c = 0; c < NUM_CH; c++)
              dout_d[c*BITWIDTH +: BITWIDTH] = (c == int'(ch_q)) ? io_conv(res) : stg_q[c];
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_MAC;
          end
        end else begin
          st_d    = st_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts the frame but keeps the last published output visible.
    if (!EN) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      sat_d   = 1'b0;
      ch_d    = '0;
      st_d    = '0;
      k_d     = '0;
      stg_d   = stg_q;
      dout_d  = dout_q;
      for (int i = 0; i < NSEC; i++) begin
        hx1_d[i] = '0;
        hx2_d[i] = '0;
        hy1_d[i] = '0;
        hy2_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      sat_q   <= 1'b0;
      ch_q    <= '0;
      st_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        xin_q[c]                       <= '0;
        stg_q[c]                       <= io_conv('0);
        dout_q[c*BITWIDTH +: BITWIDTH] <= io_conv('0);
      end
      for (int i = 0; i < NSEC; i++) begin
        hx1_q[i] <= '0;
        hx2_q[i] <= '0;
        hy1_q[i] <= '0;
        hy2_q[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= coef_reset(i);
    end else begin
      state_q <= state_d;
      start_q <= START_FLAG;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      sat_q   <= sat_d;
      ch_q    <= ch_d;
      st_q    <= st_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      xin_q   <= xin_d;
      hx1_q   <= hx1_d;
      hx2_q   <= hx2_d;
      hy1_q   <= hy1_d;
      hy2_q   <= hy2_d;
      coef_q  <= coef_d;
      stg_q   <= stg_d;
      dout_q  <= dout_d;
    end
  end

  assign DATA_OUT   = dout_q;
  assign DATA_VALID = valid_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = ovr_q;
  assign SATURATED  = sat_q;

endmodule
